i2c_slave_rx: RTL and testbench

- Synthesizable I2C slave receiver; consumes the SCL/SDA stream produced by the simulation I2C master generator.
- Oversamples both lines on the system clock, filters them, and detects START/STOP.
- Shifts in bytes MSB first, drives ACK/NACK on the 9th SCL period, and presents each received byte on a one-cycle valid/ready stream.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_slave_rx_if.sv | 24 ++
 rtl/i2c_slave_rx_in_filter.sv | 60 ++++++
 rtl/i2c_slave_rx.sv | 161 ++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receiver.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ACK,
        IGNORE
    } i2c_rx_state_t;

    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

endpackage

// File: rtl/i2c_slave_rx_if.sv
// Received-byte stream between the I2C slave receiver and its sink.
interface i2c_rx_if;
    import i2c_pkg::*;

    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_first;
    logic                  rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_first,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_first,
        output rx_ready
    );

endinterface

// File: rtl/i2c_slave_rx_in_filter.sv
// Synchronizer, glitch filter and edge pulses for one I2C line.
module i2c_in_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam int PL = SYNC_STAGES + FILT_LEN;
    localparam int PW = $clog2(PL + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [PW-1:0]          prime;
    logic                   samp;
    logic                   primed;
    logic                   flip;

    assign samp   = sync[SYNC_STAGES-1];
    assign primed = (prime == PW'(PL));
    assign flip   = (samp != level) && (cnt == CW'(FILT_LEN - 1));

    // Until the pipeline has filled, the level tracks the line silently
    // so a reset in mid-transfer cannot fake a START or STOP edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '1;
            cnt   <= '0;
            prime <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= SYNC_STAGES'({sync, line_i});
            rise <= 1'b0;
            fall <= 1'b0;
            if (!primed) begin
                prime <= prime + 1'b1;
                level <= samp;
                cnt   <= '0;
            end else if (samp == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= samp;
                cnt   <= '0;
                rise  <= samp;
                fall  <= ~samp;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C slave receiver: START/STOP detection, byte shift-in and ACK drive.
// Define I2C_SLAVE_ADDR_MATCH_EN to qualify the first byte as an address.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FILT_LEN    = 3,
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h2A
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     scl_i,
    input  logic     sda_i,
    output logic     sda_oe,
    i2c_rx_if.master rx,
    output logic     overrun,
    output logic     start_det,
    output logic     stop_det,
    output logic     busy
);

`ifdef I2C_SLAVE_ADDR_MATCH_EN
    localparam bit ADDR_EN = 1'b1;
`else
    localparam bit ADDR_EN = 1'b0;
`endif

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_in_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_scl (
        .clk   (clk),
        .rst_n (rst_n),
        .line_i(scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_in_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_sda (
        .clk   (clk),
        .rst_n (rst_n),
        .line_i(sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_rx_state_t         state;
    logic [3:0]            bit_cnt;
    logic [I2C_BYTE_W-1:0] shreg;
    logic [I2C_BYTE_W-1:0] nbyte;
    logic                  ack_bit;
    logic                  first_arm;
    logic                  vld_q;
    logic                  fst_q;
    logic                  scl_edge;
    logic                  start_c;
    logic                  stop_c;
    logic                  addr_miss;

    // An SCL edge in the same cycle masks the SDA edge.
    assign scl_edge  = scl_rise | scl_fall;
    assign start_c   = sda_fall & scl_lvl & ~scl_edge;
    assign stop_c    = sda_rise & scl_lvl & ~scl_edge;
    assign nbyte     = {shreg[I2C_BYTE_W-2:0], sda_lvl};
    assign addr_miss = ADDR_EN & first_arm &
                       (nbyte[I2C_BYTE_W-1:1] != SLAVE_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            ack_bit     <= I2C_NACK;
            first_arm   <= 1'b0;
            vld_q       <= 1'b0;
            fst_q       <= 1'b0;
            sda_oe      <= 1'b0;
            rx.rx_data  <= '0;
            rx.rx_valid <= 1'b0;
            rx.rx_first <= 1'b0;
            overrun     <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            overrun     <= 1'b0;
            vld_q       <= 1'b0;
            fst_q       <= 1'b0;
            rx.rx_valid <= vld_q;
            rx.rx_first <= fst_q;
            unique case (1'b1)
                stop_c: begin
                    state     <= IDLE;
                    bit_cnt   <= '0;
                    shreg     <= '0;
                    first_arm <= 1'b0;
                    sda_oe    <= 1'b0;
                    stop_det  <= 1'b1;
                    busy      <= 1'b0;
                end
                start_c: begin
                    state     <= DATA;
                    bit_cnt   <= '0;
                    shreg     <= '0;
                    first_arm <= 1'b1;
                    sda_oe    <= 1'b0;
                    start_det <= 1'b1;
                    busy      <= 1'b1;
                end
                default: begin
                    unique case (state)
                        IDLE: ;
                        DATA: begin
                            if (scl_rise && !bit_cnt[3]) begin
                                shreg   <= nbyte;
                                bit_cnt <= bit_cnt + 4'd1;
                                if (bit_cnt == 4'd7) begin
                                    first_arm <= 1'b0;
                                    if (addr_miss) begin
                                        ack_bit <= I2C_NACK;
                                        state   <= IGNORE;
                                    end else if (rx.rx_ready) begin
                                        rx.rx_data <= nbyte;
                                        vld_q      <= 1'b1;
                                        fst_q      <= first_arm;
                                        ack_bit    <= I2C_ACK;
                                    end else begin
                                        overrun <= 1'b1;
                                        ack_bit <= I2C_NACK;
                                    end
                                end
                            end else if (scl_fall && bit_cnt[3]) begin
                                state  <= ACK;
                                sda_oe <= (ack_bit == I2C_ACK);
                            end
                        end
                        ACK: begin
                            if (scl_fall) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= DATA;
                            end
                        end
                        IGNORE: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: table vectors, corner sequences
// and randomized transfers against a byte-level reference model.
module tb_i2c_slave_rx;

    localparam logic [6:0] ADDR = 7'h2A;
`ifdef I2C_SLAVE_ADDR_MATCH_EN
    localparam bit ADDR_EN = 1'b1;
    localparam logic [23:0] RST_SEQ = 24'h543456;
`else
    localparam bit ADDR_EN = 1'b0;
    localparam logic [23:0] RST_SEQ = 24'h123456;
`endif

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic scl_m  = 1'b1;
    logic sda_m  = 1'b1;
    logic glitch = 1'b0;
    logic scl_line, sda_line;
    logic sda_oe, overrun, start_det, stop_det, busy;

    i2c_rx_if rxif();

    assign scl_line = scl_m & ~glitch;
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_rx #(
        .SYNC_STAGES(2),
        .FILT_LEN   (3),
        .SLAVE_ADDR (ADDR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_line),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .rx       (rxif),
        .overrun  (overrun),
        .start_det(start_det),
        .stop_det (stop_det),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_stop  = 0;
    int n_ovr   = 0;
    logic [8:0] got_q[$];
    logic       ack_q[$];
    bit         oe_bad;

    always @(negedge clk) begin
        if (rxif.rx_valid) got_q.push_back({rxif.rx_first, rxif.rx_data});
        if (start_det) n_start++;
        if (stop_det) n_stop++;
        if (overrun) n_ovr++;
    end

    typedef struct {
        int          nb;
        logic [23:0] val;
        logic [2:0]  rdy;
        bit          gl;
        int          exp_nv;
        int          exp_no;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; #100;
        sda_m = 1'b0; #100;
        scl_m = 1'b0; #100;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #100;
        scl_m = 1'b1; #100;
        sda_m = 1'b1; #100;
    endtask

    task automatic send_bit(input logic b, input bit gl);
        sda_m = b; #100;
        scl_m = 1'b1;
        if (gl) begin
            #60; glitch = 1'b1; #10; glitch = 1'b0; #30;
        end else begin
            #100;
        end
        if (sda_oe) oe_bad = 1'b1;
        #100; scl_m = 1'b0; #100;
    endtask

    task automatic ack9(output logic oe);
        sda_m = 1'b1; #100;
        scl_m = 1'b1; #100;
        oe = sda_oe; #100;
        scl_m = 1'b0; #100;
    endtask

    task automatic run_xfer(input string tag, input int nb,
                            input logic [23:0] val, input logic [2:0] rdy,
                            input bit gl, output int nv, output int no);
        int s0, p0, o0, g0, eo;
        logic [7:0] bytes[3];
        logic [8:0] exq[$];
        logic       exa[3];
        logic       a;
        bit         ign;
        s0 = n_start; p0 = n_stop; o0 = n_ovr; g0 = got_q.size();
        ack_q.delete(); oe_bad = 1'b0; eo = 0; ign = 1'b0;
        for (int i = 0; i < nb; i++) bytes[i] = val[8*(nb-1-i) +: 8];
        bus_start();
        chk({tag, ":busy_on"}, busy, 1);
        for (int i = 0; i < nb; i++) begin
            rxif.rx_ready = rdy[i];
            for (int b = 7; b >= 0; b--)
                send_bit(bytes[i][b], gl && i == 0 && b == 4);
            ack9(a);
            ack_q.push_back(a);
        end
        rxif.rx_ready = 1'b1;
        bus_stop();
        #200;
        for (int i = 0; i < nb; i++) begin
            if (ign) begin
                exa[i] = 1'b0;
            end else if (ADDR_EN && i == 0 && bytes[0][7:1] != ADDR) begin
                ign = 1'b1;
                exa[i] = 1'b0;
            end else if (rdy[i]) begin
                exq.push_back({i == 0, bytes[i]});
                exa[i] = 1'b1;
            end else begin
                eo++;
                exa[i] = 1'b0;
            end
        end
        nv = got_q.size() - g0;
        no = n_ovr - o0;
        chk({tag, ":start_det"}, n_start - s0, 1);
        chk({tag, ":stop_det"}, n_stop - p0, 1);
        chk({tag, ":n_valid"}, nv, exq.size());
        chk({tag, ":n_overrun"}, no, eo);
        for (int i = 0; i < exq.size() && i < nv; i++)
            chk($sformatf("%s:byte%0d", tag, i), got_q[g0+i], exq[i]);
        for (int i = 0; i < nb; i++)
            chk($sformatf("%s:ack%0d", tag, i), ack_q[i], exa[i]);
        chk({tag, ":oe_in_data"}, oe_bad, 0);
        chk({tag, ":busy_off"}, busy, 0);
    endtask

    initial begin
        int nv, no, g0, nb;
        logic a;
        logic [7:0] rb[3];
        logic [23:0] val;
        logic [2:0] rdy;

`ifdef I2C_SLAVE_ADDR_MATCH_EN
        vt[0] = '{2, 24'h0054C3, 3'b111, 1'b0, 2, 0};
        vt[1] = '{2, 24'h0056C3, 3'b111, 1'b0, 0, 0};
        vt[2] = '{1, 24'h000055, 3'b000, 1'b0, 0, 1};
        vt[3] = '{1, 24'h000055, 3'b111, 1'b1, 1, 0};
`else
        vt[0] = '{1, 24'h0000A5, 3'b111, 1'b0, 1, 0};
        vt[1] = '{3, 24'h123456, 3'b111, 1'b0, 3, 0};
        vt[2] = '{1, 24'h00005A, 3'b000, 1'b0, 0, 1};
        vt[3] = '{1, 24'h0000A5, 3'b111, 1'b1, 1, 0};
`endif
        rxif.rx_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_flags", {sda_oe, rxif.rx_valid, rxif.rx_first, overrun,
                            start_det, stop_det, busy}, 0);
        chk("reset_data", rxif.rx_data, 0);
        #47 rst_n = 1'b1;
        #200;

        for (int i = 0; i < 4; i++) begin
            run_xfer($sformatf("vec%0d", i), vt[i].nb, vt[i].val,
                     vt[i].rdy, vt[i].gl, nv, no);
            chk($sformatf("vec%0d:tbl_valid", i), nv, vt[i].exp_nv);
            chk($sformatf("vec%0d:tbl_ovr", i), no, vt[i].exp_no);
        end

        rb[0] = RST_SEQ[23:16]; rb[1] = RST_SEQ[15:8]; rb[2] = RST_SEQ[7:0];
        g0 = got_q.size();
        ack_q.delete();
        bus_start();
        for (int b = 7; b >= 0; b--) send_bit(rb[0][b], 1'b0);
        ack9(a); ack_q.push_back(a);
        for (int b = 7; b >= 4; b--) send_bit(rb[1][b], 1'b0);
        #50 rst_n = 1'b0;
        #1;
        chk("midrst_flags", {sda_oe, rxif.rx_valid, rxif.rx_first, overrun,
                             start_det, stop_det, busy}, 0);
        chk("midrst_data", rxif.rx_data, 0);
        #29 rst_n = 1'b1;
        for (int b = 3; b >= 0; b--) send_bit(rb[1][b], 1'b0);
        chk("midrst_busy_after", busy, 0);
        ack9(a); ack_q.push_back(a);
        for (int b = 7; b >= 0; b--) send_bit(rb[2][b], 1'b0);
        ack9(a); ack_q.push_back(a);
        bus_stop();
        #200;
        chk("midrst_n_valid", got_q.size() - g0, 1);
        if (got_q.size() > g0)
            chk("midrst_byte0", got_q[g0], {1'b1, rb[0]});
        chk("midrst_ack0", ack_q[0], 1);
        chk("midrst_ack1", ack_q[1], 0);
        chk("midrst_ack2", ack_q[2], 0);
        run_xfer("post_rst", 1, ADDR_EN ? 24'h55 : 24'hA5, 3'b111, 1'b0,
                 nv, no);
        chk("post_rst_valid", nv, 1);

        for (int t = 0; t < 8; t++) begin
            nb  = $urandom_range(1, 3);
            val = 24'($urandom);
            rdy = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
            if (ADDR_EN && $urandom_range(0, 1) == 1)
                val[8*(nb-1)+1 +: 7] = ADDR;
            run_xfer($sformatf("rnd%0d", t), nb, val, rdy, 1'b0, nv, no);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
